// File: rtl/quad_encoder_reader_if.sv
// Snapshot readout port of quad_encoder_reader: one-cycle request, one-cycle valid pulse with a 32-bit word.
// The master issues rd_req; the slave (the reader) answers with data_out/data_valid on the following edge.
interface quad_encoder_reader_if;
  logic        rd_req;
  logic [31:0] data_out;
  logic        data_valid;

  modport master (output rd_req, input data_out, input data_valid);
  modport slave  (input rd_req, output data_out, output data_valid);
endinterface

// File: rtl/quad_encoder_reader.sv
// Quadrature reader: 2-flop sync, FILTER_LEN debounce, Gray decode to a wrapping signed position (FILTER_LEN+3 cycles).
// Tracks illegal jumps, answers rd_req with a registered snapshot; `ENC_PERIOD_EN adds step-interval timing.
module quad_encoder_reader #(
  parameter int unsigned FILTER_LEN = 4,
  parameter logic [21:0] TIMEOUT    = 22'd2000000
) (
  input  logic                        CLK100MHZ,
  input  logic                        reset,
  input  logic                        enc_a,
  input  logic                        enc_b,
  input  logic                        zero_pos,
  input  logic                        err_clr,
  output logic [20:0]                 position,
  output logic                        dir,
  output logic                        moving,
  output logic                        err_sticky,
  output logic [7:0]                  err_count,
  output logic [21:0]                 period,
  quad_encoder_reader_if.slave        rd_if
);

  localparam logic [3:0] FLT = 4'(FILTER_LEN);

  if (FILTER_LEN < 1 || FILTER_LEN > 15 || TIMEOUT == 22'd0) begin : g_bad_param
    $error("quad_encoder_reader: FILTER_LEN must be 1-15 and TIMEOUT nonzero");
  end

  logic [1:0]  sync1_q, sync2_q, cand_q, filt_q;
  logic [3:0]  stab_q;
  logic        ref_vld_q, fwd_q, bwd_q, ill_q;
  logic        accept;
  logic [1:0]  delta;
  logic        step_ok;

  logic [20:0] pos_q, pos_d;
  logic        dir_q, dir_d;
  logic        sticky_q, sticky_d;
  logic [7:0]  errc_q, errc_d;
  logic        moving_q;
  logic [31:0] dout_q;
  logic        dvld_q;

  // {a,b} Gray state 00,01,11,10 maps to 0,1,2,3
  function automatic logic [1:0] gray2bin(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  assign accept = (stab_q == FLT) && (!ref_vld_q || (cand_q != filt_q));
  assign delta  = gray2bin(cand_q) - gray2bin(filt_q);

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      filt_q    <= '0;
      stab_q    <= '0;
      ref_vld_q <= 1'b0;
      fwd_q     <= 1'b0;
      bwd_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      sync1_q <= {enc_a, enc_b};
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        stab_q <= 4'd1;
      end else if (stab_q != FLT) begin
        stab_q <= stab_q + 4'd1;
      end
      // The first accepted level after reset only seeds the reference
      fwd_q <= accept && ref_vld_q && (delta == 2'd1);
      bwd_q <= accept && ref_vld_q && (delta == 2'd3);
      ill_q <= accept && ref_vld_q && (delta == 2'd2);
      if (accept) begin
        filt_q    <= cand_q;
        ref_vld_q <= 1'b1;
      end
    end
  end

  assign step_ok = (fwd_q | bwd_q) & ~zero_pos;

  always_comb begin
    pos_d    = pos_q;
    dir_d    = dir_q;
    sticky_d = sticky_q;
    errc_d   = errc_q;
    if (zero_pos) begin
      pos_d = '0;
    end else if (fwd_q) begin
      pos_d = pos_q + 21'd1;
      dir_d = 1'b1;
    end else if (bwd_q) begin
      pos_d = pos_q - 21'd1;
      dir_d = 1'b0;
    end
    // A new error outranks a simultaneous clear and restarts the count at one
    if (ill_q) begin
      sticky_d = 1'b1;
      errc_d   = err_clr ? 8'd1 : ((errc_q == 8'hFF) ? errc_q : errc_q + 8'd1);
    end else if (err_clr) begin
      sticky_d = 1'b0;
      errc_d   = '0;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      pos_q    <= '0;
      dir_q    <= 1'b0;
      sticky_q <= 1'b0;
      errc_q   <= '0;
      dout_q   <= '0;
      dvld_q   <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      sticky_q <= sticky_d;
      errc_q   <= errc_d;
      dvld_q   <= rd_if.rd_req;
      if (rd_if.rd_req) begin
        dout_q <= {sticky_q, dir_q, moving_q, errc_q, pos_q};
      end
    end
  end

`ifdef ENC_PERIOD_EN
  logic [21:0] ivl_q, period_q;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      ivl_q    <= '0;
      period_q <= '0;
      moving_q <= 1'b0;
    end else if (step_ok) begin
      period_q <= ivl_q;
      ivl_q    <= 22'd1;
      moving_q <= 1'b1;
    end else begin
      if (ivl_q != 22'h3FFFFF) begin
        ivl_q <= ivl_q + 22'd1;
      end
      if (ivl_q == TIMEOUT) begin
        moving_q <= 1'b0;
        period_q <= '0;
      end
    end
  end

  assign period = period_q;
`else
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      moving_q <= 1'b0;
    end else if (zero_pos) begin
      moving_q <= 1'b0;
    end else if (step_ok) begin
      moving_q <= 1'b1;
    end
  end

  assign period = '0;
`endif

  assign position         = pos_q;
  assign dir              = dir_q;
  assign moving           = moving_q;
  assign err_sticky       = sticky_q;
  assign err_count        = errc_q;
  assign rd_if.data_out   = dout_q;
  assign rd_if.data_valid = dvld_q;

endmodule

// File: tb/tb_quad_encoder_reader.sv
// Bench for quad_encoder_reader: table of quadrature steps checked directly and through a snapshot scoreboard,
// plus hand sequences for glitch rejection, exact latency, error/clear collision, zero collision, timeout and reset.
module tb_quad_encoder_reader;
  localparam int unsigned FL  = 4;
  localparam logic [21:0] TMO = 22'd300;
`ifdef ENC_PERIOD_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]  ab;
    logic [20:0] pos;
    logic        dir;
    logic [7:0]  errc;
    logic        sticky;
    logic [21:0] per;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        enc_a, enc_b, zero_pos, err_clr;
  logic [20:0] position;
  logic        dir, moving, err_sticky;
  logic [7:0]  err_count;
  logic [21:0] period;

  quad_encoder_reader_if rd_if ();

  quad_encoder_reader #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
    .CLK100MHZ (clk),
    .reset     (rst),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .zero_pos  (zero_pos),
    .err_clr   (err_clr),
    .position  (position),
    .dir       (dir),
    .moving    (moving),
    .err_sticky(err_sticky),
    .err_count (err_count),
    .period    (period),
    .rd_if     (rd_if)
  );

  int          checks   = 0;
  int          failures = 0;
  int          n_req    = 0;
  int          n_vld    = 0;
  logic [31:0] sb [$];
  vec_t        tbl [14];
  logic [1:0]  fwd5 [5];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ab(input logic [1:0] ab);
    @(negedge clk);
    enc_a = ab[1];
    enc_b = ab[0];
  endtask

  task automatic snap(input logic [31:0] exp);
    @(negedge clk);
    rd_if.rd_req = 1'b1;
    sb.push_back(exp);
    n_req++;
    @(negedge clk);
    rd_if.rd_req = 1'b0;
  endtask

  // Scoreboard: every data_valid pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (rd_if.data_valid) begin
      n_vld++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_data_valid: got pulse with data_out %h expected none", rd_if.data_out);
      end else begin
        check("snapshot", rd_if.data_out, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b01, 21'd1, 1'b1, 8'd0, 1'b0, 22'd0};
    tbl[1]  = '{2'b11, 21'd2, 1'b1, 8'd0, 1'b0, 22'd40};
    tbl[2]  = '{2'b10, 21'd3, 1'b1, 8'd0, 1'b0, 22'd40};
    tbl[3]  = '{2'b00, 21'd4, 1'b1, 8'd0, 1'b0, 22'd40};
    tbl[4]  = '{2'b01, 21'd5, 1'b1, 8'd0, 1'b0, 22'd40};
    tbl[5]  = '{2'b11, 21'd6, 1'b1, 8'd0, 1'b0, 22'd40};
    tbl[6]  = '{2'b10, 21'd7, 1'b1, 8'd0, 1'b0, 22'd40};
    tbl[7]  = '{2'b00, 21'd8, 1'b1, 8'd0, 1'b0, 22'd40};
    tbl[8]  = '{2'b11, 21'd8, 1'b1, 8'd1, 1'b1, 22'd40};
    tbl[9]  = '{2'b01, 21'd7, 1'b0, 8'd1, 1'b1, 22'd80};
    tbl[10] = '{2'b00, 21'd6, 1'b0, 8'd1, 1'b1, 22'd40};
    tbl[11] = '{2'b01, 21'd7, 1'b1, 8'd1, 1'b1, 22'd40};
    tbl[12] = '{2'b10, 21'd7, 1'b1, 8'd2, 1'b1, 22'd40};
    tbl[13] = '{2'b00, 21'd8, 1'b1, 8'd2, 1'b1, 22'd80};
    fwd5[0] = 2'b11; fwd5[1] = 2'b10; fwd5[2] = 2'b00; fwd5[3] = 2'b01; fwd5[4] = 2'b11;

    rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; zero_pos = 1'b0; err_clr = 1'b0; rd_if.rd_req = 1'b0;
    tick(3);
    check("rst_pos", 32'(position), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_moving", 32'(moving), 32'd0);
    check("rst_sticky", 32'(err_sticky), 32'd0);
    check("rst_errc", 32'(err_count), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_dout", rd_if.data_out, 32'd0);
    check("rst_dvld", 32'(rd_if.data_valid), 32'd0);
    rst = 1'b0;
    tick(20);

    // Glitch one cycle shorter than the filter must be ignored
    enc_a = 1'b1;
    tick(3);
    enc_a = 1'b0;
    tick(20);
    check("glitch_pos", 32'(position), 32'd0);
    check("glitch_errc", 32'(err_count), 32'd0);

    for (int i = 0; i < 14; i++) begin
      drive_ab(tbl[i].ab);
      tick(37);
      check($sformatf("vec%0d_pos", i), 32'(position), 32'(tbl[i].pos));
      check($sformatf("vec%0d_dir", i), 32'(dir), 32'(tbl[i].dir));
      check($sformatf("vec%0d_errc", i), 32'(err_count), 32'(tbl[i].errc));
      check($sformatf("vec%0d_sticky", i), 32'(err_sticky), 32'(tbl[i].sticky));
      check($sformatf("vec%0d_moving", i), 32'(moving), 32'd1);
      if (!(PER_EN && i == 0))
        check($sformatf("vec%0d_period", i), 32'(period), PER_EN ? 32'(tbl[i].per) : 32'd0);
      snap({tbl[i].sticky, tbl[i].dir, 1'b1, tbl[i].errc, tbl[i].pos});
    end

    // Position must move exactly FL+3 edges after the pin change
    drive_ab(2'b01);
    tick(7);
    check("lat_early_pos", 32'(position), 32'd8);
    tick(1);
    check("lat_exact_pos", 32'(position), 32'd9);

    drive_ab(2'b10);
    tick(7);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("errclr_coll_errc", 32'(err_count), 32'd1);
    check("errclr_coll_sticky", 32'(err_sticky), 32'd1);
    check("errclr_coll_pos", 32'(position), 32'd9);
    check("errclr_coll_dir", 32'(dir), 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("errclr_errc", 32'(err_count), 32'd0);
    check("errclr_sticky", 32'(err_sticky), 32'd0);

    zero_pos = 1'b1;
    tick(1);
    zero_pos = 1'b0;
    check("zero_pos", 32'(position), 32'd0);
    check("zero_moving", 32'(moving), PER_EN ? 32'd1 : 32'd0);
    drive_ab(2'b11);
    tick(10);
    check("back_wrap_pos", 32'(position), 32'h001FFFFF);
    check("back_wrap_dir", 32'(dir), 32'd0);
    check("back_wrap_moving", 32'(moving), 32'd1);

    drive_ab(2'b01);
    tick(7);
    zero_pos = 1'b1;
    tick(1);
    zero_pos = 1'b0;
    check("zero_coll_pos", 32'(position), 32'd0);
    check("zero_coll_dir", 32'(dir), 32'd0);
    check("zero_coll_moving", 32'(moving), PER_EN ? 32'd1 : 32'd0);
    tick(4);

    for (int k = 0; k < 5; k++) begin
      drive_ab(fwd5[k]);
      tick(12);
    end
    check("fwd5_pos", 32'(position), 32'd5);
    check("fwd5_period", 32'(period), PER_EN ? 32'd13 : 32'd0);
    snap(32'h60000005);
    @(negedge clk);
    rd_if.rd_req = 1'b1;
    sb.push_back(32'h60000005);
    n_req++;
    @(negedge clk);
    sb.push_back(32'h60000005);
    n_req++;
    @(negedge clk);
    rd_if.rd_req = 1'b0;
    tick(3);

    tick(int'(TMO) + 20);
    check("timeout_moving", 32'(moving), PER_EN ? 32'd0 : 32'd1);
    check("timeout_period", 32'(period), 32'd0);

    // Reset mid-flight: pending pin change and readout request are dropped
    drive_ab(2'b10);
    tick(3);
    rd_if.rd_req = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_pos", 32'(position), 32'd0);
    check("midrst_dout", rd_if.data_out, 32'd0);
    check("midrst_dvld", 32'(rd_if.data_valid), 32'd0);
    @(negedge clk);
    rd_if.rd_req = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(20);
    check("post_rst_pos", 32'(position), 32'd0);
    check("post_rst_errc", 32'(err_count), 32'd0);
    check("post_rst_moving", 32'(moving), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("valid_pulses", 32'(n_vld), 32'(n_req));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quad_encoder_reader.md
QUAD_ENCODER_READER -- requirements
Module: quad_encoder_reader

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning the number of consecutive stable synchronized samples (range 1-15) required to accept a new A/B level.
REQ-002 SHALL have parameter TIMEOUT, default 22'd2000000, meaning the cycles without a valid step before the block reports stopped (the 50 Hz step period).
REQ-003 SHALL have port CLK100MHZ  input  1  system clock; the block has one clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports enc_a, enc_b  input  1 each  raw quadrature feedback, asynchronous to CLK100MHZ.
REQ-006 SHALL have port zero_pos  input  1  synchronous position clear.
REQ-007 SHALL have port err_clr  input  1  synchronous clear of the error flag and error count.
REQ-008 SHALL have port rd_req  input  1  one-cycle snapshot request.
REQ-009 SHALL have port position  output  21  signed step count, two's complement.
REQ-010 SHALL have ports dir (1=forward), moving, err_sticky  output  1 each.
REQ-011 SHALL have port err_count  output  8  count of illegal transitions.
REQ-012 SHALL have port period  output  22  cycles between the last two valid steps.
REQ-013 SHALL have ports data_out  output  32  and data_valid  output  1  snapshot readout.

Function
REQ-014 SHALL pass enc_a/enc_b through a 2-flop synchronizer each, then a filter accepting a new {a,b} only after FILTER_LEN consecutive identical samples.
REQ-015 SHALL decode the filtered state on acceptance: 00->01->11->10->00 is forward (+1, dir=1); the reverse sequence is backward (-1, dir=0).
REQ-016 SHALL treat a change of both bits as illegal: no position change, dir held, err_sticky set, err_count incremented and saturating at 8'hFF.
REQ-017 SHALL wrap position modulo 2^21 (21'h0FFFFF+1 -> 21'h100000; 0-1 -> 21'h1FFFFF).
REQ-018 SHALL update position and dir exactly FILTER_LEN+3 cycles after the first rising edge at which a pin change is present and held stable.
REQ-019 SHALL clear position to 0 on the edge after zero_pos=1; on collision with a valid step, zero wins and the step is discarded.
REQ-020 SHALL give err_sticky/err_count set priority over err_clr when the two occur on the same cycle; err_count becomes 1 in that case.
REQ-021 SHALL run a 22-bit interval counter that saturates at 22'h3FFFFF: on a valid step period<=counter, counter<=1, moving<=1; illegal transitions leave counter and period unchanged.
REQ-022 SHALL, when the counter reaches TIMEOUT, drive moving<=0 and period<=0 on the same cycle.
REQ-023 SHALL, on rd_req, latch data_out={err_sticky,dir,moving,err_count,position} (bits 31,30,29,28:21,20:0) on the next edge and assert data_valid for exactly that one cycle; each rd_req, including back-to-back, yields its own pulse reflecting state at the rd_req cycle.

Reset
REQ-024 SHALL on reset drive position, dir, moving, err_sticky, err_count, period, data_out and data_valid to 0, and clear the synchronizers, filter and counter.
REQ-025 SHALL mark the filter reference invalid at reset; the first accepted filtered value after release loads the reference without counting a step or error.
REQ-026 SHALL honor reset mid-operation immediately, discarding any in-progress filter count or pending readout.

Configuration
REQ-027 SHALL, with ENC_PERIOD_EN defined, implement REQ-021 and REQ-022 as stated.
REQ-028 SHALL, with ENC_PERIOD_EN undefined, omit the interval counter, tie period to 0, and set moving=1 on a valid step, clearing it only on reset or zero_pos.

Verification
REQ-029 SHALL cover: after reset, 8 forward quadrature steps 40 cycles apart -> position=8, dir=1, period=40 (ENC_PERIOD_EN).
REQ-030 SHALL cover: a 3-cycle glitch on enc_a with FILTER_LEN=4 -> position unchanged, err_count=0.
REQ-031 SHALL cover: a direct 00->11 jump -> err_sticky=1, err_count=1, position unchanged; err_clr on the same cycle as a second illegal jump -> err_count=1.
REQ-032 SHALL cover: 1 backward step from position 0 -> position=21'h1FFFFF, dir=0; zero_pos colliding with a step -> position=0.
REQ-033 SHALL cover: no steps for 2000000 cycles -> moving=0, period=0.
REQ-034 SHALL cover: rd_req at position 5 with moving=1 and dir=1 -> next cycle data_valid=1 and data_out=32'h60000005.
